// File: rtl/cordic_atan2_mag.sv
// ============================================================================
// Module      : cordic_atan2_mag
// Description : Iterative vectoring-mode CORDIC, (x, y) -> (atan2(y, x), |v|),
//               Q8.16 signed in and out, start/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_atan2_mag #(
  parameter int W          = 24,
  parameter int ITERATIONS = 16,
  parameter int GUARD      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         ready,
  output logic         busy,
  output logic [W-1:0] angle_out,
  output logic [W-1:0] mag_out
);

  localparam int XW = W + GUARD + 2;
  localparam int ZW = W + GUARD;
  localparam int PW = XW + 18;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_PREROT = 3'd1;
  localparam logic [2:0] c_ITER   = 3'd2;
  localparam logic [2:0] c_SCALE  = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  // Angle constants are in the internal Q.(16+GUARD) domain, tabulated for GUARD=2.
  localparam int c_ATAN [0:31] = '{
    205887, 121542, 64220, 32599, 16363, 8189, 4096, 2048,
    1024,   512,    256,   128,   64,    32,   16,   8,
    4,      2,      1,     0,     0,     0,    0,    0,
    0,      0,      0,     0,     0,     0,    0,    0
  };
  localparam logic signed [ZW-1:0] c_HALF_PI = ZW'(411775);
  localparam logic signed [ZW-1:0] c_PI_Z    = ZW'(205887);
  localparam logic        [W-1:0]  c_PI_OUT  = W'(205887);
  localparam logic        [16:0]   c_INV_K   = 17'h09B75;
  localparam logic signed [PW-1:0] c_MAG_MAX = PW'(2**(W-1) - 1);

  logic [2:0]              r_state;
  logic [4:0]              r_iter;
  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic signed [ZW-1:0]    r_z;
  logic                    r_zero;
  logic                    r_negx;

  logic signed [XW-1:0]    w_xs;
  logic signed [XW-1:0]    w_ys;
  logic signed [ZW-1:0]    w_atan;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_mag_sh;
  logic signed [ZW-1:0]    w_z_rnd;
  logic signed [ZW-1:0]    w_ang_full;
  logic                    w_ang_wrap;

  assign w_xs       = r_x >>> r_iter;
  assign w_ys       = r_y >>> r_iter;
  assign w_atan     = ZW'(c_ATAN[r_iter]);
  assign w_prod     = PW'(r_x) * $signed(PW'({1'b0, c_INV_K}));
  assign w_mag_sh   = w_prod >>> (16 + GUARD);
  assign w_z_rnd    = r_z + ZW'(2**(GUARD-1));
  assign w_ang_full = w_z_rnd >>> GUARD;
  // Keeps the result in (-pi, +pi]: overshoot past +pi or landing on -pi reports +pi.
  assign w_ang_wrap = (w_ang_full > c_PI_Z) || (w_ang_full <= -c_PI_Z);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_iter    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_zero    <= 1'b0;
      r_negx    <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_x     <= {{2{x_in[W-1]}}, x_in, {GUARD{1'b0}}};
            r_y     <= {{2{y_in[W-1]}}, y_in, {GUARD{1'b0}}};
            r_zero  <= (x_in == '0) && (y_in == '0);
            r_negx  <= (y_in == '0) && x_in[W-1];
            ready   <= 1'b0;
            busy    <= 1'b1;
            r_state <= c_PREROT;
          end
        end
        c_PREROT: begin
          if (!r_x[XW-1]) begin
            r_z <= '0;
          end else if (!r_y[XW-1]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= c_HALF_PI;
          end else begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -c_HALF_PI;
          end
          r_iter  <= '0;
          r_state <= c_ITER;
        end
        c_ITER: begin
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_iter <= r_iter + 5'd1;
          if (r_iter == 5'(ITERATIONS - 1)) begin
            r_state <= c_SCALE;
          end
        end
        c_SCALE: begin
          if (r_zero) begin
            angle_out <= '0;
            mag_out   <= '0;
          end else begin
            angle_out <= (r_negx || w_ang_wrap) ? c_PI_OUT : w_ang_full[W-1:0];
            if (w_mag_sh[PW-1]) begin
              mag_out <= '0;
            end else if (w_mag_sh > c_MAG_MAX) begin
              mag_out <= {1'b0, {(W-1){1'b1}}};
            end else begin
              mag_out <= w_mag_sh[W-1:0];
            end
          end
          ready   <= 1'b1;
          busy    <= 1'b0;
          r_state <= c_DONE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_atan2_mag.sv
// ============================================================================
// Module      : tb_cordic_atan2_mag
// Description : Directed-vector bench for cordic_atan2_mag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_atan2_mag;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         ready;
  logic         busy;
  logic [W-1:0] angle_out;
  logic [W-1:0] mag_out;

  int n_cmp = 0;
  int n_err = 0;

  cordic_atan2_mag #(
    .W          (W),
    .ITERATIONS (16),
    .GUARD      (2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .ready     (ready),
    .busy      (busy),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp, input int tol);
    int diff;
    diff = int'($signed(got)) - int'($signed(exp));
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got 0x%06h expected 0x%06h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ready_drop", W'(ready), W'(0), 0);
    check("busy_set", W'(busy), W'(1), 0);
  endtask

  task automatic wait_ready(input int first_edge, output int lat);
    lat = first_edge;
    while (!ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] ea, input logic [W-1:0] em,
                     input int ta, input int tm);
    int lat;
    launch(x, y);
    wait_ready(0, lat);
    check({tag, "_lat"}, W'(lat), W'(18), 0);
    check({tag, "_ang"}, angle_out, ea, ta);
    check({tag, "_mag"}, mag_out, em, tm);
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", W'(ready), W'(0), 0);
    check("rst_busy", W'(busy), W'(0), 0);
    check("rst_ang", angle_out, W'(0), 0);
    check("rst_mag", mag_out, W'(0), 0);
    @(negedge clk);
    reset = 1'b1;

    vec("px",   24'h010000, 24'h000000, 24'h000000, 24'h010000, 8, 16);
    vec("diag", 24'h010000, 24'h010000, 24'h00C910, 24'h016A0A, 8, 16);
    vec("py",   24'h000000, 24'h010000, 24'h01921F, 24'h010000, 8, 16);
    vec("ny",   24'h000000, 24'hFF0000, 24'hFE6DE1, 24'h010000, 8, 16);
    vec("nx",   24'hFF0000, 24'h000000, 24'h03243F, 24'h010000, 0, 16);
    vec("nxny", 24'hFF0000, 24'hFF0000, 24'hFDA4D0, 24'h016A0A, 8, 16);
    vec("zero", 24'h000000, 24'h000000, 24'h000000, 24'h000000, 0, 0);
    vec("sat",  24'h7F0000, 24'h7F0000, 24'h00C910, 24'h7FFFFF, 8, 0);

    // A second start and changed operands during the iterations must be ignored.
    launch(24'h010000, 24'h010000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    x_in  = 24'hFF0000;
    y_in  = 24'hFF0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy", W'(busy), W'(1), 0);
    wait_ready(6, lat);
    check("mid_lat", W'(lat), W'(18), 0);
    check("mid_ang", angle_out, 24'h00C910, 8);
    check("mid_mag", mag_out, 24'h016A0A, 16);

    // Reset lands on the edge that would run iteration 5.
    launch(24'h010000, 24'h010000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", W'(ready), W'(0), 0);
    check("abort_busy", W'(busy), W'(0), 0);
    check("abort_ang", angle_out, W'(0), 0);
    check("abort_mag", mag_out, W'(0), 0);
    @(negedge clk);
    reset = 1'b1;
    vec("fresh", 24'h000000, 24'h010000, 24'h01921F, 24'h010000, 8, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
